// File: rtl/ula_pkg.sv
// Shared constants for the ula sequencer: command opcodes, ALU selector
// codes and FSM state encoding. MUL_LOOP exists only when ULA_SEQ_MUL_EN
// is defined.
package ula_pkg;

  // Command opcodes
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  // ula selector codes
  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;
  localparam logic [2:0] SEL_SHR = 3'b010;
  localparam logic [2:0] SEL_SHL = 3'b011;

  // FSM state type and encodings
  typedef logic [1:0] estado_t;
  localparam estado_t OCIOSO   = 2'd0;
  localparam estado_t EXEC     = 2'd1;
`ifdef ULA_SEQ_MUL_EN
  localparam estado_t MUL_LOOP = 2'd2;
`endif

endpackage

// File: rtl/ula_sequenciador.sv
// Accumulator sequencer in front of the external 4-bit ula ALU.
// Accepts one command per valid/ready handshake, executes it through the
// shared ALU and pulses res_valid when acc/flags are written back.
// Optional feature: define ULA_SEQ_MUL_EN to enable the repeated-add MUL
// opcode; otherwise opcode 101 behaves exactly like NOP.
module ula_sequenciador
  import ula_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_dado,
  output logic [3:0] ula_a,
  output logic [3:0] ula_b,
  output logic [2:0] ula_sel,
  input  logic [4:0] ula_s,
  input  logic       ula_cout,
  output logic [3:0] acc,
  output logic       flag_c,
  output logic       flag_z,
  output logic       res_valid
);

  estado_t    r_estado;
  logic [2:0] r_op;
  logic [3:0] r_dado;
  logic [3:0] r_acc;
  logic       r_c;
  logic       r_z;
  logic       r_res_valid;

`ifdef ULA_SEQ_MUL_EN
  logic [3:0] r_cnt;
  logic [3:0] r_prod;
  logic [3:0] r_mcand;
  logic       r_c_acc;
  logic       w_inicia_mul;
`endif

  logic [3:0] w_acc_novo;
  logic       w_c_novo;
  logic       w_atualiza;   // write acc, C and Z this cycle
  logic       w_fim;        // operation completes this cycle -> res_valid next
  logic       w_unused_s4;

  // The carry comes from ula_cout; bit 4 of the sum is intentionally ignored.
  assign w_unused_s4 = ula_s[4];

  assign cmd_ready = (r_estado == OCIOSO);
  assign acc       = r_acc;
  assign flag_c    = r_c;
  assign flag_z    = r_z;
  assign res_valid = r_res_valid;

  // ALU operand steering: idle holds a=acc, b=0, sel=add so no stale operands reach the ALU
  always_comb begin
    ula_a   = r_acc;
    ula_b   = 4'd0;
    ula_sel = SEL_ADD;
    case (r_estado)
      EXEC: begin
        case (r_op)
          OP_ADD: begin
            ula_b   = r_dado;
            ula_sel = SEL_ADD;
          end
          OP_SUB: begin
            ula_b   = r_dado;
            ula_sel = SEL_SUB;
          end
          OP_SHR: begin
            ula_b   = r_acc;
            ula_sel = SEL_SHR;
          end
          OP_SHL: begin
            ula_b   = r_acc;
            ula_sel = SEL_SHL;
          end
          default: ;
        endcase
      end
`ifdef ULA_SEQ_MUL_EN
      MUL_LOOP: begin
        ula_a   = r_prod;
        ula_b   = r_mcand;
        ula_sel = SEL_ADD;
      end
`endif
      default: ;
    endcase
  end

  // Writeback decode: next acc/C and whether this cycle completes an operation
  always_comb begin
    w_acc_novo   = r_acc;
    w_c_novo     = r_c;
    w_atualiza   = 1'b0;
    w_fim        = 1'b0;
`ifdef ULA_SEQ_MUL_EN
    w_inicia_mul = 1'b0;
`endif
    case (r_estado)
      EXEC: begin
        w_fim = 1'b1;
        case (r_op)
          OP_ADD, OP_SUB, OP_SHL: begin
            w_acc_novo = ula_s[3:0];
            w_c_novo   = ula_cout;
            w_atualiza = 1'b1;
          end
          OP_SHR: begin
            // shifted-out bit is taken directly from the accumulator
            w_acc_novo = ula_s[3:0];
            w_c_novo   = r_acc[0];
            w_atualiza = 1'b1;
          end
          OP_LOAD: begin
            w_acc_novo = r_dado;
            w_c_novo   = 1'b0;
            w_atualiza = 1'b1;
          end
          OP_CLR: begin
            w_acc_novo = 4'd0;
            w_c_novo   = 1'b0;
            w_atualiza = 1'b1;
          end
`ifdef ULA_SEQ_MUL_EN
          OP_MUL: begin
            if (r_dado == 4'd0) begin
              w_acc_novo = 4'd0;
              w_c_novo   = 1'b0;
              w_atualiza = 1'b1;
            end else begin
              w_fim        = 1'b0;
              w_inicia_mul = 1'b1;
            end
          end
          OP_NOP: ;
`else
          OP_MUL, OP_NOP: ;
`endif
          default: ;
        endcase
      end
`ifdef ULA_SEQ_MUL_EN
      MUL_LOOP: begin
        if (r_cnt == 4'd1) begin
          w_acc_novo = ula_s[3:0];
          w_c_novo   = r_c_acc | ula_cout;
          w_atualiza = 1'b1;
          w_fim      = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // FSM, command latch and accumulator/flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado    <= OCIOSO;
      r_acc       <= 4'd0;
      r_c         <= 1'b0;
      r_z         <= 1'b1;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= w_fim;
      case (r_estado)
        OCIOSO: begin
          if (cmd_valid) begin
            r_op     <= cmd_op;
            r_dado   <= cmd_dado;
            r_estado <= EXEC;
          end
        end
        EXEC: begin
`ifdef ULA_SEQ_MUL_EN
          r_estado <= w_inicia_mul ? MUL_LOOP : OCIOSO;
`else
          r_estado <= OCIOSO;
`endif
        end
`ifdef ULA_SEQ_MUL_EN
        MUL_LOOP: begin
          if (r_cnt == 4'd1) r_estado <= OCIOSO;
        end
`endif
        default: r_estado <= OCIOSO;
      endcase
      if (w_atualiza) begin
        r_acc <= w_acc_novo;
        r_c   <= w_c_novo;
        r_z   <= (w_acc_novo == 4'd0);
      end
    end
  end

`ifdef ULA_SEQ_MUL_EN
  // Repeated-add multiply datapath: prod accumulates mcand, cnt times
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_prod  <= 4'd0;
      r_mcand <= 4'd0;
      r_c_acc <= 1'b0;
    end else if (w_inicia_mul) begin
      r_prod  <= 4'd0;
      r_mcand <= r_acc;
      r_cnt   <= r_dado;
      r_c_acc <= 1'b0;
    end else if (r_estado == MUL_LOOP) begin
      r_prod  <= ula_s[3:0];
      r_c_acc <= r_c_acc | ula_cout;
      r_cnt   <= r_cnt - 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed testbench for ula_sequenciador with a behavioural ula model.
// MUL scenarios are selected by ULA_SEQ_MUL_EN to match the RTL build.
module tb_ula_sequenciador;

  localparam logic [2:0] C_ADD = 3'b000, C_SUB = 3'b001, C_SHR = 3'b010, C_SHL = 3'b011;
  localparam logic [2:0] C_LOAD = 3'b100, C_MUL = 3'b101, C_CLR = 3'b110, C_NOP = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_dado;
  logic [3:0] ula_a, ula_b;
  logic [2:0] ula_sel;
  logic [4:0] ula_s;
  logic       ula_cout;
  logic [3:0] acc;
  logic       flag_c, flag_z, res_valid;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ula_sequenciador dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_dado(cmd_dado),
    .ula_a(ula_a), .ula_b(ula_b), .ula_sel(ula_sel), .ula_s(ula_s), .ula_cout(ula_cout),
    .acc(acc), .flag_c(flag_c), .flag_z(flag_z), .res_valid(res_valid)
  );

  // Behavioural model of the external ula
  always_comb begin
    ula_s    = 5'd0;
    ula_cout = 1'b0;
    case (ula_sel)
      3'b000: begin ula_s = {1'b0, ula_a} + {1'b0, ula_b}; ula_cout = ula_s[4]; end
      3'b001: begin ula_s = {1'b0, ula_a} - {1'b0, ula_b}; ula_cout = ula_s[4]; end
      3'b010: begin ula_s = {2'b00, ula_b[3:1]};           ula_cout = 1'b0;     end
      3'b011: begin ula_s = {ula_b, 1'b0};                 ula_cout = ula_b[3]; end
      default: ;
    endcase
  end

  // Issue one command and measure negedges from the accept edge to res_valid (-1 on timeout)
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] d, output int lat);
    int w;
    lat = -1;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    if (!cmd_ready) return;
    cmd_op = op; cmd_dado = d; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (res_valid) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = C_NOP; cmd_dado = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({acc, flag_c, flag_z, res_valid, cmd_ready} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got acc=%0d c=%b z=%b rv=%b rdy=%b, expected acc=0 c=0 z=1 rv=0 rdy=1",
               acc, flag_c, flag_z, res_valid, cmd_ready);
    end
    n_chk++;
    if ({ula_a, ula_b, ula_sel} !== {4'd0, 4'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_alu_idle: got a=%0d b=%0d sel=%b, expected a=0 b=0 sel=000", ula_a, ula_b, ula_sel);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    do_cmd(C_LOAD, 4'd9, lat);
    n_chk++;
    if ({acc, flag_c, flag_z} !== {4'd9, 1'b0, 1'b0} || lat !== 2) begin
      n_fail++;
      $display("FAIL load_9: got acc=%0d c=%b z=%b lat=%0d, expected acc=9 c=0 z=0 lat=2", acc, flag_c, flag_z, lat);
    end
    n_chk++;
    if ({ula_a, ula_b, ula_sel} !== {4'd9, 4'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL idle_operands: got a=%0d b=%0d sel=%b, expected a=9 b=0 sel=000", ula_a, ula_b, ula_sel);
    end
    do_cmd(C_ADD, 4'd9, lat);
    n_chk++;
    if ({acc, flag_c, flag_z} !== {4'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL add_9_9: got acc=%0d c=%b z=%b, expected acc=2 c=1 z=0", acc, flag_c, flag_z);
    end
    n_chk++;
    if (lat !== 2 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL add_timing: got lat=%0d rdy=%b, expected lat=2 rdy=1", lat, cmd_ready);
    end
    @(negedge clk);
    n_chk++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rv_single_pulse: got rv=%b, expected rv=0", res_valid);
    end
  endtask

  task automatic test_sub();
    int lat;
    do_cmd(C_LOAD, 4'd3, lat);
    do_cmd(C_SUB, 4'd3, lat);
    n_chk++;
    if ({acc, flag_c, flag_z} !== {4'd0, 1'b0, 1'b1} || lat !== 2) begin
      n_fail++;
      $display("FAIL sub_3_3: got acc=%0d c=%b z=%b lat=%0d, expected acc=0 c=0 z=1 lat=2", acc, flag_c, flag_z, lat);
    end
    do_cmd(C_SUB, 4'd1, lat);
    n_chk++;
    if ({acc, flag_c, flag_z} !== {4'd15, 1'b1, 1'b0} || lat !== 2) begin
      n_fail++;
      $display("FAIL sub_borrow: got acc=%0d c=%b z=%b lat=%0d, expected acc=15 c=1 z=0 lat=2", acc, flag_c, flag_z, lat);
    end
  endtask

  task automatic test_shift();
    int lat;
    do_cmd(C_LOAD, 4'd5, lat);
    do_cmd(C_SHR, 4'd0, lat);
    n_chk++;
    if ({acc, flag_c, flag_z} !== {4'd2, 1'b1, 1'b0} || lat !== 2) begin
      n_fail++;
      $display("FAIL shr_5: got acc=%0d c=%b z=%b lat=%0d, expected acc=2 c=1 z=0 lat=2", acc, flag_c, flag_z, lat);
    end
    do_cmd(C_LOAD, 4'd12, lat);
    do_cmd(C_SHL, 4'd0, lat);
    n_chk++;
    if ({acc, flag_c, flag_z} !== {4'd8, 1'b1, 1'b0} || lat !== 2) begin
      n_fail++;
      $display("FAIL shl_12: got acc=%0d c=%b z=%b lat=%0d, expected acc=8 c=1 z=0 lat=2", acc, flag_c, flag_z, lat);
    end
    do_cmd(C_NOP, 4'd5, lat);
    n_chk++;
    if ({acc, flag_c, flag_z} !== {4'd8, 1'b1, 1'b0} || lat !== 2) begin
      n_fail++;
      $display("FAIL nop_hold: got acc=%0d c=%b z=%b lat=%0d, expected acc=8 c=1 z=0 lat=2", acc, flag_c, flag_z, lat);
    end
    do_cmd(C_CLR, 4'd5, lat);
    n_chk++;
    if ({acc, flag_c, flag_z} !== {4'd0, 1'b0, 1'b1} || lat !== 2) begin
      n_fail++;
      $display("FAIL clr: got acc=%0d c=%b z=%b lat=%0d, expected acc=0 c=0 z=1 lat=2", acc, flag_c, flag_z, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat, pulses, consec;
    logic prev;
    do_cmd(C_CLR, 4'd0, lat);
    pulses = 0; consec = 0; prev = 1'b0;
    cmd_op = C_ADD; cmd_dado = 4'd1; cmd_valid = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (res_valid) begin
        pulses++;
        if (prev) consec++;
      end
      prev = res_valid;
    end
    cmd_valid = 1'b0;
    n_chk++;
    if (acc !== 4'd3 || pulses !== 3 || consec !== 0) begin
      n_fail++;
      $display("FAIL back_to_back: got acc=%0d pulses=%0d consecutive=%0d, expected acc=3 pulses=3 consecutive=0",
               acc, pulses, consec);
    end
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (acc !== 4'd3 || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle: got acc=%0d rv=%b rdy=%b, expected acc=3 rv=0 rdy=1", acc, res_valid, cmd_ready);
    end
  endtask

`ifdef ULA_SEQ_MUL_EN
  task automatic test_mul();
    int lat;
    do_cmd(C_LOAD, 4'd3, lat);
    do_cmd(C_MUL, 4'd5, lat);
    n_chk++;
    if ({acc, flag_c, flag_z} !== {4'd15, 1'b0, 1'b0} || lat !== 7) begin
      n_fail++;
      $display("FAIL mul_3x5: got acc=%0d c=%b z=%b lat=%0d, expected acc=15 c=0 z=0 lat=7", acc, flag_c, flag_z, lat);
    end
    do_cmd(C_MUL, 4'd2, lat);
    n_chk++;
    if ({acc, flag_c, flag_z} !== {4'd14, 1'b1, 1'b0} || lat !== 4) begin
      n_fail++;
      $display("FAIL mul_15x2: got acc=%0d c=%b z=%b lat=%0d, expected acc=14 c=1 z=0 lat=4", acc, flag_c, flag_z, lat);
    end
    do_cmd(C_MUL, 4'd0, lat);
    n_chk++;
    if ({acc, flag_c, flag_z} !== {4'd0, 1'b0, 1'b1} || lat !== 2) begin
      n_fail++;
      $display("FAIL mul_x0: got acc=%0d c=%b z=%b lat=%0d, expected acc=0 c=0 z=1 lat=2", acc, flag_c, flag_z, lat);
    end
  endtask

  task automatic test_hold_during_mul();
    int lat, busy;
    do_cmd(C_LOAD, 4'd3, lat);
    @(negedge clk);
    cmd_op = C_MUL; cmd_dado = 4'd4; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_op = C_LOAD; cmd_dado = 4'd1;
    busy = 0; lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (res_valid) begin lat = i; break; end
      if (!cmd_ready) busy++;
    end
    n_chk++;
    if (acc !== 4'd12 || lat !== 6 || busy !== 5) begin
      n_fail++;
      $display("FAIL hold_mul: got acc=%0d lat=%0d busy=%0d, expected acc=12 lat=6 busy=5", acc, lat, busy);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (res_valid) begin lat = i; break; end
    end
    n_chk++;
    if (acc !== 4'd1 || lat !== 2) begin
      n_fail++;
      $display("FAIL held_load: got acc=%0d lat=%0d, expected acc=1 lat=2", acc, lat);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat, pulses;
    do_cmd(C_LOAD, 4'd3, lat);
    @(negedge clk);
    cmd_op = C_MUL; cmd_dado = 4'd5; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    @(negedge clk);
    n_chk++;
    if ({acc, flag_c, flag_z, cmd_ready} !== {4'd0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_mul: got acc=%0d c=%b z=%b rdy=%b, expected acc=0 c=0 z=1 rdy=1",
               acc, flag_c, flag_z, cmd_ready);
    end
    for (int i = 0; i < 8; i++) begin
      if (res_valid) pulses++;
      @(negedge clk);
    end
    n_chk++;
    if (pulses !== 0 || acc !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_no_wb: got pulses=%0d acc=%0d, expected pulses=0 acc=0", pulses, acc);
    end
    do_cmd(C_LOAD, 4'd2, lat);
    do_cmd(C_MUL, 4'd2, lat);
    n_chk++;
    if ({acc, flag_c, flag_z} !== {4'd4, 1'b0, 1'b0} || lat !== 4) begin
      n_fail++;
      $display("FAIL mul_after_abort: got acc=%0d c=%b z=%b lat=%0d, expected acc=4 c=0 z=0 lat=4", acc, flag_c, flag_z, lat);
    end
  endtask
`else
  task automatic test_mul_as_nop();
    int lat;
    do_cmd(C_LOAD, 4'd7, lat);
    do_cmd(C_MUL, 4'd3, lat);
    n_chk++;
    if ({acc, flag_c, flag_z} !== {4'd7, 1'b0, 1'b0} || lat !== 2) begin
      n_fail++;
      $display("FAIL mul_nop_7: got acc=%0d c=%b z=%b lat=%0d, expected acc=7 c=0 z=0 lat=2", acc, flag_c, flag_z, lat);
    end
    do_cmd(C_LOAD, 4'd12, lat);
    do_cmd(C_SHL, 4'd0, lat);
    do_cmd(C_MUL, 4'd3, lat);
    n_chk++;
    if ({acc, flag_c, flag_z} !== {4'd8, 1'b1, 1'b0} || lat !== 2) begin
      n_fail++;
      $display("FAIL mul_nop_flags: got acc=%0d c=%b z=%b lat=%0d, expected acc=8 c=1 z=0 lat=2", acc, flag_c, flag_z, lat);
    end
    do_cmd(C_MUL, 4'd0, lat);
    n_chk++;
    if ({acc, flag_c, flag_z} !== {4'd8, 1'b1, 1'b0} || lat !== 2) begin
      n_fail++;
      $display("FAIL mul_nop_zero: got acc=%0d c=%b z=%b lat=%0d, expected acc=8 c=1 z=0 lat=2", acc, flag_c, flag_z, lat);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_back_to_back();
`ifdef ULA_SEQ_MUL_EN
    test_mul();
    test_hold_during_mul();
    test_reset_mid_mul();
`else
    test_mul_as_nop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
